// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO merging load and ALU results into one register-file write port,
// with combinational forwarding of the youngest pending write per lookup register.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [3:0]               mem_reg,
   input  logic [15:0]              mem_data,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [3:0]               alu_reg,
   input  logic [15:0]              alu_data,
   output logic                     write_en,
   output logic [3:0]               write_reg,
   output logic [15:0]              write_data,
   input  logic [3:0]               lookup_reg1,
   input  logic [3:0]               lookup_reg2,
   output logic                     fwd_hit1,
   output logic                     fwd_hit2,
   output logic [15:0]              fwd_data1,
   output logic [15:0]              fwd_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   logic [3:0]    q_reg  [DEPTH];
   logic [15:0]   q_data [DEPTH];
   logic [AW-1:0] head, tail, idx;
   logic [AW+1:0] space;
   logic          mem_push, alu_push, pop;
   assign empty = count == '0;
   assign full  = count == (AW+1)'(DEPTH);
   // The head always pops this cycle, so its slot counts as free.
   assign space     = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(!empty);
   assign mem_ready = |space;
   assign alu_ready = mem_valid ? |space[AW+1:1] : |space;
   assign mem_push  = mem_valid & mem_ready & (mem_reg[3:1] != 3'd0);
   assign alu_push  = alu_valid & alu_ready & (alu_reg[3:1] != 3'd0);
   assign pop        = !empty;
   assign write_en   = pop;
   assign write_reg  = empty ? 4'd0 : q_reg[head];
   assign write_data = empty ? 16'd0 : q_data[head];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(mem_push) + AW'(alu_push);
         count <= count + (AW+1)'(mem_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (mem_push) begin
         q_reg[tail]  <= mem_reg;
         q_data[tail] <= mem_data;
      end
      if (alu_push) begin
         q_reg[tail + AW'(mem_push)]  <= alu_reg;
         q_data[tail + AW'(mem_push)] <= alu_data;
      end
   end
   // Scan oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = 16'd0;
      fwd_hit2  = 1'b0;
      fwd_data2 = 16'd0;
      idx       = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if ((AW+1)'(i) < count) begin
            if (lookup_reg1[3:1] != 3'd0 && q_reg[idx] == lookup_reg1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = q_data[idx];
            end
            if (lookup_reg2[3:1] != 3'd0 && q_reg[idx] == lookup_reg2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = q_data[idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vector table for writeback_queue (DEPTH=4) plus an async-reset sequence.
module tb_writeback_queue;
   logic        clk = 1'b0, rst = 1'b1;
   logic        mem_valid = 1'b0, alu_valid = 1'b0;
   logic [3:0]  mem_reg = '0, alu_reg = '0, lookup_reg1 = '0, lookup_reg2 = '0;
   logic [15:0] mem_data = '0, alu_data = '0;
   logic        mem_ready, alu_ready, write_en, fwd_hit1, fwd_hit2, empty, full;
   logic [3:0]  write_reg;
   logic [15:0] write_data, fwd_data1, fwd_data2;
   logic [2:0]  count;
   int checks = 0, failures = 0;

   writeback_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
      .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic rst; logic mv; logic [3:0] mreg; logic [15:0] md;
      logic av; logic [3:0] areg; logic [15:0] ad; logic [3:0] l1; logic [3:0] l2;
   } in_t;
   typedef struct packed {
      logic mr; logic ar; logic we; logic [3:0] wr; logic [15:0] wd; logic [2:0] cnt;
      logic emp; logic ful; logic h1; logic [15:0] d1; logic h2; logic [15:0] d2;
   } out_t;
   typedef struct packed { in_t i; out_t o; } vec_t;

   function automatic in_t vi(logic r, logic mv, logic [3:0] mreg, logic [15:0] md,
                              logic av, logic [3:0] areg, logic [15:0] ad, logic [3:0] l1, logic [3:0] l2);
      return '{r, mv, mreg, md, av, areg, ad, l1, l2};
   endfunction
   function automatic in_t idle(logic r, logic [3:0] l1, logic [3:0] l2);
      return '{r, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, l1, l2};
   endfunction
   function automatic out_t vo(logic mr, logic ar, logic we, logic [3:0] wr, logic [15:0] wd, logic [2:0] cnt,
                               logic emp, logic ful, logic h1, logic [15:0] d1, logic h2, logic [15:0] d2);
      return '{mr, ar, we, wr, wd, cnt, emp, ful, h1, d1, h2, d2};
   endfunction

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   vec_t tv[$];
   out_t got, mt;

   initial begin
      mt = vo(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tv.push_back('{idle(1, 0, 0), mt});
      tv.push_back('{vi(0, 0, 0, 0, 1, 5, 16'h1234, 5, 0), mt});
      tv.push_back('{idle(0, 5, 0), vo(1, 1, 1, 5, 16'h1234, 1, 0, 0, 1, 16'h1234, 0, 0)});
      tv.push_back('{idle(0, 5, 0), mt});
      tv.push_back('{vi(0, 1, 3, 16'hAAAA, 1, 4, 16'hBBBB, 0, 0), mt});
      tv.push_back('{idle(0, 3, 4), vo(1, 1, 1, 3, 16'hAAAA, 2, 0, 0, 1, 16'hAAAA, 1, 16'hBBBB)});
      tv.push_back('{idle(0, 3, 4), vo(1, 1, 1, 4, 16'hBBBB, 1, 0, 0, 0, 0, 1, 16'hBBBB)});
      tv.push_back('{idle(0, 3, 4), mt});
      tv.push_back('{vi(0, 1, 6, 16'h6001, 1, 7, 16'h7001, 6, 7), mt});
      tv.push_back('{vi(0, 1, 6, 16'h6002, 1, 7, 16'h7002, 6, 7), vo(1, 1, 1, 6, 16'h6001, 2, 0, 0, 1, 16'h6001, 1, 16'h7001)});
      tv.push_back('{vi(0, 1, 8, 16'h8001, 1, 9, 16'h9001, 7, 6), vo(1, 1, 1, 7, 16'h7001, 3, 0, 0, 1, 16'h7002, 1, 16'h6002)});
      tv.push_back('{vi(0, 1, 10, 16'hA001, 1, 11, 16'hB001, 7, 11), vo(1, 0, 1, 6, 16'h6002, 4, 0, 1, 1, 16'h7002, 0, 0)});
      tv.push_back('{idle(0, 10, 11), vo(1, 1, 1, 7, 16'h7002, 4, 0, 1, 1, 16'hA001, 0, 0)});
      tv.push_back('{idle(1, 8, 9), mt});
      tv.push_back('{idle(0, 8, 9), mt});
      tv.push_back('{idle(0, 8, 9), mt});
      tv.push_back('{vi(0, 1, 7, 16'h0001, 1, 7, 16'h0002, 7, 1), mt});
      tv.push_back('{idle(0, 7, 1), vo(1, 1, 1, 7, 16'h0001, 2, 0, 0, 1, 16'h0002, 0, 0)});
      tv.push_back('{idle(0, 7, 1), vo(1, 1, 1, 7, 16'h0002, 1, 0, 0, 1, 16'h0002, 0, 0)});
      tv.push_back('{vi(0, 0, 0, 0, 1, 1, 16'hFFFF, 1, 0), mt});
      tv.push_back('{idle(0, 1, 0), mt});
      tv.push_back('{vi(0, 1, 0, 16'h0F0F, 1, 2, 16'h2222, 2, 0), mt});
      tv.push_back('{idle(0, 2, 0), vo(1, 1, 1, 2, 16'h2222, 1, 0, 0, 1, 16'h2222, 0, 0)});
      tv.push_back('{idle(0, 2, 0), mt});

      foreach (tv[k]) begin
         @(negedge clk);
         {rst, mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, lookup_reg1, lookup_reg2} = tv[k].i;
         #2;
         got = '{mem_ready, alu_ready, write_en, write_reg, write_data, count, empty, full,
                 fwd_hit1, fwd_data1, fwd_hit2, fwd_data2};
         checks++;
         if (got !== tv[k].o) begin
            failures++;
            $display("FAIL vec%0d got=%h exp=%h", k, got, tv[k].o);
         end
      end

      // Reset asserted between edges must flush pending entries at once.
      @(negedge clk);
      {mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data} = {1'b1, 4'd8, 16'h8888, 1'b1, 4'd9, 16'h9999};
      @(negedge clk);
      {mem_valid, alu_valid, lookup_reg1} = {1'b0, 1'b0, 4'd9};
      #1 chk("seq_count2", 32'(count), 32'd2);
      chk("seq_hit9", 32'(fwd_hit1), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("seq_rst_count", 32'(count), 32'd0);
      chk("seq_rst_we", 32'(write_en), 32'd0);
      chk("seq_rst_hit", 32'(fwd_hit1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2 chk("seq_no_stale_we", 32'(write_en), 32'd0);
         chk("seq_no_stale_cnt", 32'(count), 32'd0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
